mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It produces the 2-bit ALUOp consumed by the ALU-control opcode/funct selector: 10 selects Funct, 11 selects Opcode for I-type ALU ops. It stalls on a memory-ready handshake and keeps a retired-instruction count.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- Opcode  in  6  IR[31:26]
- Zero  in  1  ALU zero flag (consumed by datapath via PCWriteCond; unused in FSM)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 opcode
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- state  out  4  current state, debug
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- illegal_op  out  1  sticky, set on undecodable opcode
- instr_count  out  CNT_W  retired instructions

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IMMEXEC 10, IMMWB 11; codes 12-15 → FETCH.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite=1 only while mem_ready=1; advance to DECODE on mem_ready, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next: 000000→RTEXEC; 100011/101011→MEMADR; 000100→BRANCH; 000010→JUMP; 001000/001100/001101/001010→IMMEXEC; anything else → FETCH, set illegal_op, pulse instr_done.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw→MEMRD, sw→MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB. ALUWB: RegDst=1, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- IMMEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 → IMMWB. IMMWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- instr_done=1 in MEMWB, ALUWB, BRANCH, JUMP, IMMWB, MEMWR-with-mem_ready, DECODE-illegal. instr_count increments on the same cycle (including illegal); wraps modulo 2^CNT_W.
- mem_ready ignored outside FETCH/MEMRD/MEMWR.

## Timing
- Registered state; control outputs decoded combinationally from state (plus mem_ready gating in FETCH/MEMWR).
- While reset=1: state=FETCH, instr_count=0, illegal_op=0, and PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, instr_done forced 0; other outputs show FETCH values.
- Reset mid-instruction: immediate return to FETCH, no partial write issued after assertion.
- CPI with mem_ready tied high: R 4, lw 5, sw 4, beq 3, j 3, I-ALU 4; each wait cycle on mem_ready adds 1.

## Structure
- Shared package/header mips_ctrl_pkg: state codes, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI), ALUOp codes, ALUSrcB/PCSource codes.
- One sub-module: mips_ctrl_outdec, combinational state+mem_ready → control outputs; FSM, counter and sticky flag in top.

## Test plan
- Reset high, mem_ready=1 → state=0, RegWrite=MemWrite=MemRead=0, instr_count=0; release → MemRead=1, IRWrite=1, state=1 next cycle.
- Opcode 000000, mem_ready=1 → states 0,1,6,7; ALUOp=10 in 6; RegDst=RegWrite=1 in 7; instr_done once; instr_count=1.
- Opcode 100011, mem_ready low 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4; MemtoReg=1 in 4; CPI 8.
- Opcode 001101 → state 10 with ALUOp=11, ALUSrcB=10; state 11 RegWrite=1, RegDst=0.
- Opcode 111111 → DECODE→FETCH, illegal_op=1 and stays 1 through later valid instructions until reset.
- Reset asserted during MEMWR with mem_ready=0 → MemWrite drops same cycle, state=0, instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state codes, opcodes and datapath select encodings
// for the multi-cycle MIPS main control FSM.
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTEXEC  = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_IMMEXEC = 4'd10,
    ST_IMMWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_OPCODE = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Successor of DECODE; ST_FETCH doubles as the "undecodable" marker.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                          return ST_RTEXEC;
      OP_LW, OP_SW:                      return ST_MEMADR;
      OP_BEQ:                            return ST_BRANCH;
      OP_J:                              return ST_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return ST_IMMEXEC;
      default:                           return ST_FETCH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational decode of FSM state (and mem_ready) into
// datapath enables and mux selects; hold suppresses all side effects.
`default_nettype none

module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       decode_illegal,
  input  logic       hold,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;

    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        instr_done = decode_illegal;
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      ST_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_IMMEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_OPCODE;
      end
      ST_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // Muxes keep showing FETCH values under reset; only side effects are killed.
    if (hold) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multi-cycle MIPS datapath,
// with memory-ready stalls, sticky illegal-opcode flag and retired count.
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t cur_state;
  state_t nxt_state;
  logic   decode_illegal;
  logic   unused_zero;

  // Zero only matters to the datapath's conditional PC write.
  assign unused_zero    = Zero;
  assign decode_illegal = (cur_state == ST_DECODE) && (decode_next(Opcode) == ST_FETCH);
  assign state          = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= ST_FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = ST_FETCH;
    case (cur_state)
      ST_FETCH:   nxt_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:  nxt_state = decode_next(Opcode);
      ST_MEMADR:  nxt_state = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   nxt_state = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:   nxt_state = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTEXEC:  nxt_state = ST_ALUWB;
      ST_IMMEXEC: nxt_state = ST_IMMWB;
      default:    nxt_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      if (instr_done)     instr_count <= instr_count + CNT_W'(1);
      if (decode_illegal) illegal_op  <= 1'b1;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state          (cur_state),
    .mem_ready      (mem_ready),
    .decode_illegal (decode_illegal),
    .hold           (reset),
    .PCWrite        (PCWrite),
    .PCWriteCond    (PCWriteCond),
    .IorD           (IorD),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .IRWrite        (IRWrite),
    .MemtoReg       (MemtoReg),
    .RegDst         (RegDst),
    .RegWrite       (RegWrite),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .ALUOp          (ALUOp),
    .PCSource       (PCSource),
    .instr_done     (instr_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven instruction traces with a scoreboard
// of expected per-cycle control vectors, plus reset corner sequences.
`default_nettype none
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       state;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] instr_count;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {state, 10 enables, ALUSrcB, ALUOp, PCSource, instr_done}
  logic [20:0] dut_vec;
  assign dut_vec = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

  // Per-cycle states read left to right from the top nibble of sts; mr likewise from bit 11.
  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  len;
    logic [47:0] sts;
    logic [11:0] mr;
  } vec_t;

  vec_t        tbl [11];
  logic [20:0] sb [$];
  int          checks   = 0;
  int          failures = 0;
  int          exp_cnt;
  logic        exp_ill;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
  endfunction

  function automatic logic [20:0] model(input logic [3:0] st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin srcb = 2'b11; done = !legal(op); end
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = mr; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; done = 1; end
      4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd10: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts just after a rising edge with the DUT in FETCH.
  task automatic run_vec(input vec_t e, input int idx, input bit retire);
    Opcode = e.op;
    for (int k = 0; k < int'(e.len); k++) begin
      logic [3:0]  st;
      logic [20:0] exp;
      st        = e.sts[47-4*k -: 4];
      mem_ready = e.mr[11-k];
      sb.push_back(model(st, mem_ready, e.op));
      @(negedge clk);
      exp = sb.pop_front();
      chk($sformatf("vec%0d_cyc%0d_ctrl", idx, k), {11'd0, dut_vec}, {11'd0, exp});
      @(posedge clk);
      #1;
    end
    if (retire) begin
      exp_cnt++;
      if (!legal(e.op)) exp_ill = 1'b1;
      chk($sformatf("vec%0d_instr_count", idx), instr_count, exp_cnt);
      chk($sformatf("vec%0d_illegal_op", idx), {31'd0, illegal_op}, {31'd0, exp_ill});
    end
  endtask

  initial begin
    tbl[0]  = '{op: 6'b000000, len: 4'd4, sts: 48'h0167_0000_0000, mr: 12'b1100_0000_0000};
    tbl[1]  = '{op: 6'b100011, len: 4'd8, sts: 48'h0123_3334_0000, mr: 12'b1110_0011_0000};
    tbl[2]  = '{op: 6'b001101, len: 4'd4, sts: 48'h01AB_0000_0000, mr: 12'b1111_0000_0000};
    tbl[3]  = '{op: 6'b101011, len: 4'd5, sts: 48'h0125_5000_0000, mr: 12'b1110_1000_0000};
    tbl[4]  = '{op: 6'b000100, len: 4'd3, sts: 48'h0180_0000_0000, mr: 12'b1110_0000_0000};
    tbl[5]  = '{op: 6'b000010, len: 4'd3, sts: 48'h0190_0000_0000, mr: 12'b1110_0000_0000};
    tbl[6]  = '{op: 6'b001000, len: 4'd5, sts: 48'h001A_B000_0000, mr: 12'b0111_1000_0000};
    tbl[7]  = '{op: 6'b111111, len: 4'd2, sts: 48'h0100_0000_0000, mr: 12'b1100_0000_0000};
    tbl[8]  = '{op: 6'b001100, len: 4'd4, sts: 48'h01AB_0000_0000, mr: 12'b1111_0000_0000};
    tbl[9]  = '{op: 6'b001010, len: 4'd4, sts: 48'h01AB_0000_0000, mr: 12'b1111_0000_0000};
    tbl[10] = '{op: 6'b100011, len: 4'd5, sts: 48'h0123_4000_0000, mr: 12'b1111_1000_0000};

    reset = 1'b1; mem_ready = 1'b1; Opcode = 6'd0; Zero = 1'b0;
    exp_cnt = 0; exp_ill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state",      {28'd0, state}, 32'd0);
    chk("rst_regwrite",   {31'd0, RegWrite}, 32'd0);
    chk("rst_memwrite",   {31'd0, MemWrite}, 32'd0);
    chk("rst_memread",    {31'd0, MemRead}, 32'd0);
    chk("rst_irwrite",    {31'd0, IRWrite}, 32'd0);
    chk("rst_pcwrite",    {31'd0, PCWrite}, 32'd0);
    chk("rst_alusrcb",    {30'd0, ALUSrcB}, 32'd1);
    chk("rst_count",      instr_count, 32'd0);
    chk("rst_illegal",    {31'd0, illegal_op}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i, 1'b1);

    // Reset while a store is stalled: the write must vanish immediately.
    run_vec('{op: 6'b101011, len: 4'd3, sts: 48'h0120_0000_0000, mr: 12'b1110_0000_0000}, 20, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_stall_state",    {28'd0, state}, 32'd5);
    chk("memwr_stall_memwrite", {31'd0, MemWrite}, 32'd1);
    chk("memwr_stall_done",     {31'd0, instr_done}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("midrst_state",    {28'd0, state}, 32'd0);
    chk("midrst_count",    instr_count, 32'd0);
    chk("midrst_illegal",  {31'd0, illegal_op}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 0; exp_ill = 1'b0;
    run_vec(tbl[0], 21, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
